// File: rtl/dff_shift_bank_async.sv
// Parameterised bank of DEPTH registers of WIDTH bits supporting hold, shift,
// broadcast load and rotate, with an occupancy count and asynchronous reset.
module dff_shift_bank_async #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter logic [WIDTH-1:0]  SET_VAL   = '1
) (
  input  logic                         clk,
  input  logic                         async_reset,
  input  logic                         sync_reset,
  input  logic                         sync_set,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q_out,
  output logic [WIDTH*DEPTH-1:0]       q_all,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         full
);

  localparam int FILL_W = $clog2(DEPTH+1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  logic [WIDTH-1:0]  stage     [DEPTH];
  logic [WIDTH-1:0]  stage_nxt [DEPTH];
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_nxt;

  // Occupancy count stops at DEPTH; the oldest entry is simply overwritten.
  function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] v);
    return (v == FILL_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    stage_nxt = stage;
    fill_nxt  = fill_reg;
    if (sync_reset) begin
      for (int i = 0; i < DEPTH; i++) stage_nxt[i] = RESET_VAL;
      fill_nxt = '0;
    end else if (sync_set) begin
      for (int i = 0; i < DEPTH; i++) stage_nxt[i] = SET_VAL;
      fill_nxt = FILL_MAX;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          stage_nxt = stage;
        end
        MODE_SHIFT: begin
          stage_nxt[0] = d;
          for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
          fill_nxt = sat_inc(fill_reg);
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) stage_nxt[i] = d;
          fill_nxt = FILL_MAX;
        end
        MODE_ROTATE: begin
          stage_nxt[0] = stage[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
        end
        default: begin
          stage_nxt = stage;
        end
      endcase
    end
  end

  // Register stage: reset overrides any clock edge while it is held high.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      fill_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= stage_nxt[i];
      fill_reg <= fill_nxt;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign q_all[g*WIDTH +: WIDTH] = stage[g];
  end

  assign q_out = stage[DEPTH-1];
  assign fill  = fill_reg;
  assign full  = (fill_reg == FILL_MAX);

endmodule

// File: tb/tb_dff_shift_bank_async.sv
// Self-checking bench for dff_shift_bank_async: directed vector table, hand
// sequences around asynchronous reset, random traffic and an asynchronous soak.
module tb_dff_shift_bank_async;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  // One time unit stands for 0.1 ns; the clock period is 20 ns.
  localparam int HALF = 100;

  logic              clk = 1'b0;
  logic              async_reset;
  logic              sync_reset;
  logic              sync_set;
  logic              en;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q_out;
  logic [31:0]       q_all;
  logic [2:0]        fill;
  logic              full;

  int n_checks = 0;
  int n_pass   = 0;

  dff_shift_bank_async #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00), .SET_VAL(8'hFF)
  ) dut (
    .clk(clk), .async_reset(async_reset), .sync_reset(sync_reset),
    .sync_set(sync_set), .en(en), .mode(mode), .d(d),
    .q_out(q_out), .q_all(q_all), .fill(fill), .full(full)
  );

  always #HALF clk = ~clk;

  // Reference model: mq[0] is the entry nearest the input, mq[DEPTH-1] the output.
  logic [7:0] mq[$];
  int         mfill;

  function automatic void model_fill_all(input logic [7:0] v, input int f);
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(v);
    mfill = f;
  endfunction

  function automatic logic [31:0] model_all();
    logic [31:0] r;
    for (int i = 0; i < DEPTH; i++) r[i*8 +: 8] = mq[i];
    return r;
  endfunction

  always @(posedge clk or posedge async_reset) begin
    logic [7:0] tmp;
    if (async_reset)      model_fill_all(8'h00, 0);
    else if (sync_reset)  model_fill_all(8'h00, 0);
    else if (sync_set)    model_fill_all(8'hFF, DEPTH);
    else if (en) begin
      case (mode)
        2'b01: begin
          mq.push_front(d);
          tmp = mq.pop_back();
          mfill = (mfill < DEPTH) ? mfill + 1 : DEPTH;
        end
        2'b10: model_fill_all(d, DEPTH);
        2'b11: begin
          tmp = mq.pop_back();
          mq.push_front(tmp);
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, exp);
  endtask

  typedef struct {
    string       name;
    logic        sr;
    logic        ss;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  d;
    logic [31:0] q;
    int          fill;
  } vec_t;

  vec_t tbl[$];

  task automatic apply(input vec_t v);
    @(negedge clk);
    sync_reset = v.sr; sync_set = v.ss; en = v.en; mode = v.mode; d = v.d;
    @(posedge clk);
    #10;
    check({v.name, ".q_all"}, q_all, v.q);
    check({v.name, ".fill"},  fill,  v.fill);
    check({v.name, ".full"},  full,  (v.fill == DEPTH));
    check({v.name, ".q_out"}, q_out, v.q[31:24]);
  endtask

  task automatic apply_in(input string name, input logic sr, input logic ss, input logic e,
                          input logic [1:0] m, input logic [7:0] dv,
                          input logic [31:0] q, input int f);
    vec_t v;
    v.name = name; v.sr = sr; v.ss = ss; v.en = e; v.mode = m; v.d = dv; v.q = q; v.fill = f;
    apply(v);
  endtask

  initial begin
    model_fill_all(8'h00, 0);
    async_reset = 1'b1; sync_reset = 1'b0; sync_set = 1'b0;
    en = 1'b0; mode = 2'b00; d = 8'h00;

    tbl.push_back('{"shift1",   0,0,1,2'b01,8'h11,32'h00000011,1});
    tbl.push_back('{"shift2",   0,0,1,2'b01,8'h22,32'h00001122,2});
    tbl.push_back('{"shift3",   0,0,1,2'b01,8'h33,32'h00112233,3});
    tbl.push_back('{"shift4",   0,0,1,2'b01,8'h44,32'h11223344,4});
    tbl.push_back('{"rot1",     0,0,1,2'b11,8'hEE,32'h22334411,4});
    tbl.push_back('{"rot2",     0,0,1,2'b11,8'hEE,32'h33441122,4});
    tbl.push_back('{"rot3",     0,0,1,2'b11,8'hEE,32'h44112233,4});
    tbl.push_back('{"rot4",     0,0,1,2'b11,8'hEE,32'h11223344,4});
    tbl.push_back('{"shift5",   0,0,1,2'b01,8'h55,32'h22334455,4});
    tbl.push_back('{"hold",     0,0,1,2'b00,8'h99,32'h22334455,4});
    tbl.push_back('{"rst_set",  1,1,1,2'b10,8'h5A,32'h00000000,0});
    tbl.push_back('{"set",      0,1,1,2'b10,8'h5A,32'hFFFFFFFF,4});
    tbl.push_back('{"srst",     1,0,0,2'b01,8'h77,32'h00000000,0});
    tbl.push_back('{"shift_a1", 0,0,1,2'b01,8'hA1,32'h000000A1,1});
    tbl.push_back('{"set_en0",  0,1,0,2'b01,8'h12,32'hFFFFFFFF,4});
    tbl.push_back('{"rot_ones", 0,0,1,2'b11,8'h00,32'hFFFFFFFF,4});
    tbl.push_back('{"srst_en0", 1,0,0,2'b10,8'h34,32'h00000000,0});
    tbl.push_back('{"load_a5",  0,0,1,2'b10,8'hA5,32'hA5A5A5A5,4});

    #50;
    check("reset.q_all", q_all, 32'h0);
    check("reset.fill",  fill,  0);
    check("reset.full",  full,  1'b0);
    #100;
    async_reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous pulse between edges clears everything before the next edge.
    #30 async_reset = 1'b1;
    #20 async_reset = 1'b0;
    #10;
    check("apulse.q_all", q_all, 32'h0);
    check("apulse.fill",  fill,  0);
    check("apulse.full",  full,  1'b0);

    // en low freezes the bank while mode and d wiggle.
    apply_in("load_c3", 0,0,1,2'b10,8'hC3,32'hC3C3C3C3,4);
    for (int i = 0; i < 10; i++)
      apply_in("en0_hold", 0,0,0,2'b01,(i % 2) ? 8'hAA : 8'h55,32'hC3C3C3C3,4);
    apply_in("load_3c", 0,0,1,2'b10,8'h3C,32'h3C3C3C3C,4);

    // In-flight data is dropped by a mid-shift reset; the next edge resumes.
    apply_in("mid_s1", 1,0,0,2'b00,8'h00,32'h00000000,0);
    apply_in("mid_s2", 0,0,1,2'b01,8'h01,32'h00000001,1);
    apply_in("mid_s3", 0,0,1,2'b01,8'h02,32'h00000102,2);
    #30 async_reset = 1'b1;
    apply_in("rst_ign", 0,0,1,2'b10,8'h66,32'h00000000,0);
    #30 async_reset = 1'b0;
    apply_in("resume", 0,0,1,2'b01,8'h09,32'h00000009,1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sync_reset = ($urandom_range(0, 19) == 0);
      sync_set   = ($urandom_range(0, 14) == 0);
      en         = ($urandom_range(0, 3) != 0);
      mode       = 2'($urandom_range(0, 3));
      d          = 8'($urandom);
      @(posedge clk);
      #10;
      check("rand.q_all", q_all, model_all());
      check("rand.fill",  fill,  mfill);
      check("rand.full",  full,  (mfill == DEPTH));
      check("rand.q_out", q_out, mq[DEPTH-1]);
    end

    // Soak with d and async_reset changing off the clock grid.
    @(negedge clk);
    sync_reset = 1'b0; sync_set = 1'b0; en = 1'b1; mode = 2'b01;
    fork
      begin
        #5;
        for (int k = 0; k < 130; k++) begin
          d = 8'($urandom);
          #230;
        end
      end
      begin
        #3;
        for (int k = 0; k < 5; k++) begin
          #5470;
          async_reset = ~async_reset;
        end
      end
      begin
        #7;
        for (int k = 0; k < 3000; k++) begin
          if (async_reset) begin
            check("soak_rst.q_all", q_all, 32'h0);
            check("soak_rst.fill",  fill,  0);
          end else begin
            check("soak.q_all", q_all, model_all());
            check("soak.fill",  fill,  mfill);
          end
          #10;
        end
      end
    join
    async_reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
